// File: rtl/prog_memory_pkg.sv
// Shared constants and loader state encoding for the program memory.
package prog_memory_pkg;

   localparam int unsigned PM_BYTE_WIDTH = 8;
   localparam int unsigned PM_NUM_LANES  = 4;
   localparam int unsigned PM_MEM_DEPTH  = 1024;
   localparam int unsigned PM_ADDR_WIDTH = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } ld_state_e;

endpackage

// File: rtl/prog_memory_bank.sv
// One byte lane of program storage: single write port, registered read port.
module prog_memory_bank #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 256,
   parameter int unsigned ROW_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we_i,
   input  logic [ROW_W-1:0] waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [ROW_W-1:0] raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Storage has no reset so it maps onto plain RAM; contents survive rst_n.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_memory.sv
// Byte-laned program memory with PC read port, direct write port and bulk loader.
// Define PROG_MEMORY_ALIGN_CHK_EN to flag and suppress misaligned writes/loads via err.
module prog_memory
   import prog_memory_pkg::*;
#(
   parameter int unsigned BYTE_WIDTH = PM_BYTE_WIDTH,
   parameter int unsigned NUM_LANES  = PM_NUM_LANES,
   parameter int unsigned MEM_DEPTH  = PM_MEM_DEPTH,
   parameter int unsigned ADDR_WIDTH = PM_ADDR_WIDTH
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            rd_en,
   input  logic [ADDR_WIDTH-1:0]           rd_addr,
   output logic [BYTE_WIDTH*NUM_LANES-1:0] rd_data,
   output logic                            rd_valid,
   input  logic                            wr_en,
   input  logic [ADDR_WIDTH-1:0]           wr_addr,
   input  logic [BYTE_WIDTH*NUM_LANES-1:0] wr_data,
   input  logic [NUM_LANES-1:0]            wr_be,
   input  logic                            ld_start,
   input  logic [ADDR_WIDTH-1:0]           ld_base,
   input  logic [ADDR_WIDTH-1:0]           ld_len,
   input  logic                            ld_valid,
   input  logic [BYTE_WIDTH*NUM_LANES-1:0] ld_data,
   output logic                            ld_ready,
   output logic                            ld_busy,
   output logic                            ld_done,
   output logic                            err
);

   localparam int unsigned DATA_WIDTH = BYTE_WIDTH * NUM_LANES;
   localparam int unsigned LANE_BITS  = $clog2(NUM_LANES);
   localparam int unsigned ROW_W      = ADDR_WIDTH - LANE_BITS;
   localparam int unsigned ROWS       = MEM_DEPTH / NUM_LANES;

   ld_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [ADDR_WIDTH-1:0] rem_q, rem_d;
   logic                  rd_valid_q;
   logic                  err_q, err_d;

   logic                  wr_mis, ld_mis, load_beat;
   logic [NUM_LANES-1:0]  bank_we;
   logic [ROW_W-1:0]      bank_wrow;
   logic [DATA_WIDTH-1:0] bank_wdata;
   logic                  unused_lsbs;

`ifdef PROG_MEMORY_ALIGN_CHK_EN
   assign wr_mis = wr_en && (wr_addr[LANE_BITS-1:0] != '0);
   assign ld_mis = ld_start && (ld_base[LANE_BITS-1:0] != '0);
`else
   assign wr_mis = 1'b0;
   assign ld_mis = 1'b0;
`endif

   assign unused_lsbs = ^{rd_addr[LANE_BITS-1:0], wr_addr[LANE_BITS-1:0], ld_base[LANE_BITS-1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         rem_q      <= '0;
         rd_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         rem_q      <= rem_d;
         rd_valid_q <= rd_en;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      // ld_start is only examined in IDLE, so a misaligned start while busy is ignored too.
      err_d   = err_q | wr_mis | (ld_mis && (state_q == IDLE));
      unique case (state_q)
         IDLE: begin
            if (ld_start && !ld_mis) begin
               if (ld_len == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = LOAD;
                  ptr_d   = {ld_base[ADDR_WIDTH-1:LANE_BITS], {LANE_BITS{1'b0}}};
                  rem_d   = ld_len;
               end
            end
         end
         LOAD: begin
            if (ld_valid) begin
               ptr_d = ptr_q + ADDR_WIDTH'(NUM_LANES);
               rem_d = rem_q - ADDR_WIDTH'(1);
               if (rem_q == ADDR_WIDTH'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ld_ready  = (state_q == LOAD);
   assign ld_busy   = (state_q != IDLE);
   assign ld_done   = (state_q == DONE);
   assign load_beat = ld_ready && ld_valid;
   assign rd_valid  = rd_valid_q;
   assign err       = err_q;

   // A load beat owns the write port for the whole word; a colliding direct write is lost.
   always_comb begin
      bank_wrow  = wr_addr[ADDR_WIDTH-1:LANE_BITS];
      bank_wdata = wr_data;
      bank_we    = '0;
      if (load_beat) begin
         bank_wrow  = ptr_q[ADDR_WIDTH-1:LANE_BITS];
         bank_wdata = ld_data;
         bank_we    = '1;
      end else if (wr_en && !wr_mis) begin
         bank_we    = wr_be;
      end
   end

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      prog_memory_bank #(
         .WIDTH (BYTE_WIDTH),
         .DEPTH (ROWS),
         .ROW_W (ROW_W)
      ) u_bank (
         .clk     (clk),
         .rst_n   (rst_n),
         .we_i    (bank_we[k]),
         .waddr_i (bank_wrow),
         .wdata_i (bank_wdata[BYTE_WIDTH*k +: BYTE_WIDTH]),
         .re_i    (rd_en),
         .raddr_i (rd_addr[ADDR_WIDTH-1:LANE_BITS]),
         .rdata_o (rd_data[BYTE_WIDTH*k +: BYTE_WIDTH])
      );
   end

endmodule

// File: tb/tb_prog_memory.sv
// Directed self-checking bench for prog_memory (default 8x4 lanes, 1 KiB).
module tb_prog_memory;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rd_en;
   logic [9:0]  rd_addr;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        wr_en;
   logic [9:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic        ld_start;
   logic [9:0]  ld_base;
   logic [9:0]  ld_len;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic        ld_ready;
   logic        ld_busy;
   logic        ld_done;
   logic        err;

   int n_vec = 0;
   int n_err = 0;
   int done_cnt = 0;
   int done_base;

   always #5 clk = ~clk;

   always @(posedge clk) if (ld_done) done_cnt++;

   prog_memory #(
      .BYTE_WIDTH (8),
      .NUM_LANES  (4),
      .MEM_DEPTH  (1024),
      .ADDR_WIDTH (10)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_be    (wr_be),
      .ld_start (ld_start),
      .ld_base  (ld_base),
      .ld_len   (ld_len),
      .ld_valid (ld_valid),
      .ld_data  (ld_data),
      .ld_ready (ld_ready),
      .ld_busy  (ld_busy),
      .ld_done  (ld_done),
      .err      (err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wr_word(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
      tick();
      wr_en = 1'b0; wr_be = '0;
   endtask

   task automatic rd_check(input string tag, input logic [9:0] a, input logic [31:0] exp);
      rd_en = 1'b1; rd_addr = a;
      tick();
      rd_en = 1'b0;
      check({tag, ".valid"}, {31'd0, rd_valid}, 32'd1);
      check(tag, rd_data, exp);
   endtask

   task automatic start_load(input logic [9:0] base, input logic [9:0] len);
      ld_start = 1'b1; ld_base = base; ld_len = len;
      tick();
      ld_start = 1'b0;
   endtask

   task automatic beat(input logic [31:0] d);
      ld_valid = 1'b1; ld_data = d;
      tick();
      ld_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0;
      wr_data = '0; wr_be = '0; ld_start = 1'b0; ld_base = '0; ld_len = '0;
      ld_valid = 1'b0; ld_data = '0;
      tick(); tick();
      check("rst.rd_valid", {31'd0, rd_valid}, 32'd0);
      check("rst.rd_data",  rd_data, 32'd0);
      check("rst.ld_busy",  {31'd0, ld_busy}, 32'd0);
      check("rst.ld_ready", {31'd0, ld_ready}, 32'd0);
      check("rst.ld_done",  {31'd0, ld_done}, 32'd0);
      check("rst.err",      {31'd0, err}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Full-word write and read-back, then rd_data holds with rd_valid low.
      wr_word(10'h008, 32'hDEADBEEF, 4'hF);
      rd_check("rd008", 10'h008, 32'hDEADBEEF);
      tick();
      check("hold.valid", {31'd0, rd_valid}, 32'd0);
      check("hold.data", rd_data, 32'hDEADBEEF);

      // Byte-enabled merge.
      wr_word(10'h010, 32'h11223344, 4'hF);
      wr_word(10'h010, 32'hAABBCCDD, 4'b0101);
      rd_check("be_merge", 10'h010, 32'h11BB33DD);
      wr_word(10'h010, 32'hFFFFFFFF, 4'h0);
      rd_check("be_zero", 10'h010, 32'h11BB33DD);

      // Same-row read/write collision returns old data; low read addr bits ignored.
      rd_en = 1'b1; rd_addr = 10'h00B;
      wr_word(10'h008, 32'h55667788, 4'hF);
      rd_en = 1'b0;
      check("collide.old", rd_data, 32'hDEADBEEF);
      rd_check("collide.new", 10'h008, 32'h55667788);

      // Wrapping load with ld_valid gapped every other cycle.
      done_base = done_cnt;
      start_load(10'h3F8, 10'd4);
      check("ld.busy", {31'd0, ld_busy}, 32'd1);
      check("ld.ready", {31'd0, ld_ready}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("ld.stall_busy", {31'd0, ld_busy}, 32'd1);
         check("ld.stall_done", {31'd0, ld_done}, 32'd0);
         beat(32'(i + 1));
      end
      check("ld.done", {31'd0, ld_done}, 32'd1);
      check("ld.done_ready", {31'd0, ld_ready}, 32'd0);
      tick();
      check("ld.idle_busy", {31'd0, ld_busy}, 32'd0);
      check("ld.idle_done", {31'd0, ld_done}, 32'd0);
      check("ld.done_pulses", 32'(done_cnt - done_base), 32'd1);
      rd_check("ld.3F8", 10'h3F8, 32'd1);
      rd_check("ld.3FC", 10'h3FC, 32'd2);
      rd_check("ld.000", 10'h000, 32'd3);
      rd_check("ld.004", 10'h004, 32'd4);

      // Load beat beats a direct write to the same row; ld_start in LOAD ignored.
      start_load(10'h020, 10'd1);
      wr_en = 1'b1; wr_addr = 10'h020; wr_data = 32'h12345678; wr_be = 4'hF;
      ld_start = 1'b1; ld_base = 10'h100; ld_len = 10'd0;
      beat(32'hCAFEF00D);
      wr_en = 1'b0; wr_be = '0; ld_start = 1'b0;
      check("prio.done", {31'd0, ld_done}, 32'd1);
      tick();
      check("prio.no_restart", {31'd0, ld_busy}, 32'd0);
      rd_check("prio.020", 10'h020, 32'hCAFEF00D);

      // Zero-length load goes straight to DONE.
      start_load(10'h080, 10'd0);
      check("len0.done", {31'd0, ld_done}, 32'd1);
      check("len0.ready", {31'd0, ld_ready}, 32'd0);
      tick();
      check("len0.idle", {31'd0, ld_busy}, 32'd0);

      // Reset mid-load.
      start_load(10'h040, 10'd4);
      beat(32'h000000A0);
      beat(32'h000000A1);
      rst_n = 1'b0;
      #1;
      check("midrst.busy", {31'd0, ld_busy}, 32'd0);
      check("midrst.ready", {31'd0, ld_ready}, 32'd0);
      check("midrst.rd_data", rd_data, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      rd_check("midrst.040", 10'h040, 32'h000000A0);
      rd_check("midrst.044", 10'h044, 32'h000000A1);
      start_load(10'h048, 10'd1);
      check("relaunch.ready", {31'd0, ld_ready}, 32'd1);
      beat(32'h000000B0);
      check("relaunch.done", {31'd0, ld_done}, 32'd1);
      tick();
      rd_check("relaunch.048", 10'h048, 32'h000000B0);

      // Misaligned direct write.
      wr_word(10'h010, 32'h77777777, 4'hF);
      wr_word(10'h013, 32'h99999999, 4'hF);
`ifdef PROG_MEMORY_ALIGN_CHK_EN
      check("mis.err", {31'd0, err}, 32'd1);
      rd_check("mis.010", 10'h010, 32'h77777777);
`else
      check("mis.err", {31'd0, err}, 32'd0);
      rd_check("mis.010", 10'h010, 32'h99999999);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
